mem_copy_engine: RTL

Memory-side initiator that drives the single-port 256x16 data RAM (8-bit address, write enable, 16-bit write data, combinational read data) to copy a block of words from a source address range to a destination range. It sits between the control path and the data RAM: control issues a one-cycle start with source, destination and length, and the engine sequences read and write cycles on the RAM port. It also returns a wrapping 16-bit checksum of the words moved.

---
 rtl/mem_copy_engine_if.sv | 21 ++
 rtl/mem_copy_engine.sv | 113 +++++++++++
 2 files changed

// File: rtl/mem_copy_engine_if.sv
// rtl/mem_copy_engine_if.sv - single-port 256x16 data RAM bus between copy engine and RAM
interface mem_copy_engine_if;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_we,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_we,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - word-by-word RAM block copy with wrapping 16-bit checksum
module mem_copy_engine (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [7:0]                src_addr,
  input  logic [7:0]                dst_addr,
  input  logic [8:0]                len,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               checksum,
  mem_copy_engine_if.master         mem
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  logic [7:0]  src_ptr;
  logic [7:0]  dst_ptr;
  logic [8:0]  count;
  logic [15:0] data_reg;
  logic [7:0]  addr_q;
  logic        we_q;
  logic [8:0]  len_clamped;

  assign len_clamped   = (len > 9'd256) ? 9'd256 : len;

  // RAM port driven only from registers, so mem_rdata never loops back into mem_addr.
  assign mem.mem_addr  = addr_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_wdata = data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      src_ptr  <= 8'h00;
      dst_ptr  <= 8'h00;
      count    <= 9'd0;
      data_reg <= 16'h0000;
      checksum <= 16'h0000;
      addr_q   <= 8'h00;
      we_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_ptr  <= src_addr;
            dst_ptr  <= dst_addr;
            count    <= len_clamped;
            checksum <= 16'h0000;
            busy     <= 1'b1;
            if (len_clamped != 9'd0) begin
              state  <= READ;
              addr_q <= src_addr;
            end else begin
              state  <= DONE;
              done   <= 1'b1;
              addr_q <= 8'h00;
            end
          end
        end

        READ: begin
          data_reg <= mem.mem_rdata;
          checksum <= checksum + mem.mem_rdata;
          src_ptr  <= src_ptr + 8'd1;
          state    <= WRITE;
          addr_q   <= dst_ptr;
          we_q     <= 1'b1;
        end

        WRITE: begin
          dst_ptr <= dst_ptr + 8'd1;
          count   <= count - 9'd1;
          we_q    <= 1'b0;
          // src_ptr already advanced during READ, so it names the next word.
          if (count != 9'd1) begin
            state  <= READ;
            addr_q <= src_ptr;
          end else begin
            state  <= DONE;
            done   <= 1'b1;
            addr_q <= 8'h00;
          end
        end

        DONE: begin
          state  <= IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          addr_q <= 8'h00;
          we_q   <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          addr_q <= 8'h00;
          we_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule
